// File: rtl/pcie_tx_pkg.sv
// rtl/pcie_tx_pkg.sv - shared widths and FSM state encoding for the PCIe TX arbiter
package pcie_tx_pkg;

  localparam int TDATA_W    = 64;
  localparam int TKEEP_W    = 8;
  localparam int TUSER_W    = 4;
  localparam int BEAT_CNT_W = 8;
  localparam int PKT_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2,
    ST_CFG   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// rtl/pcie_tx_arbiter_if.sv - one TLP stream (data, keep, last, valid, user, ready)
interface pcie_tx_arbiter_if;
  import pcie_tx_pkg::*;

  logic [TDATA_W-1:0] tdata;
  logic [TKEEP_W-1:0] tkeep;
  logic               tlast;
  logic               tvalid;
  logic [TUSER_W-1:0] tuser;
  logic               tready;

  modport master (
    output tdata, tkeep, tlast, tvalid, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid, tuser,
    output tready
  );

endinterface

// File: rtl/pcie_tx_rr_pick.sv
// rtl/pcie_tx_rr_pick.sv - two-requester one-hot grant pick, purely combinational
module pcie_tx_rr_pick #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_winner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      // On contention favour whichever port did not win last time.
      if ((ROUND_ROBIN != 0) && !last_winner) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - locks the PCIe TX channel to one requester per TLP, with a config-engine grant
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_BEATS   = 130
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  pcie_tx_arbiter_if.slave     p0,
  pcie_tx_arbiter_if.slave     p1,
  pcie_tx_arbiter_if.master    s_axis_tx,
  input  logic                 tx_cfg_req,
  output logic                 tx_cfg_gnt,
  output logic [PKT_CNT_W-1:0] p0_pkt_cnt,
  output logic [PKT_CNT_W-1:0] p1_pkt_cnt,
  output logic                 overlong
);

  localparam logic [BEAT_CNT_W-1:0] OVL_AT = BEAT_CNT_W'(MAX_BEATS);

  arb_state_e           state_q, state_d;
  logic                 last_winner_q, last_winner_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PKT_CNT_W-1:0] p0_pkt_cnt_q, p0_pkt_cnt_d;
  logic [PKT_CNT_W-1:0] p1_pkt_cnt_q, p1_pkt_cnt_d;
  logic                 overlong_q, overlong_d;
  logic                 cfg_gnt_q, cfg_gnt_d;
  logic                 busy0, busy1, beat_acc, tlp_done;
  logic [1:0]           pick_gnt;

  pcie_tx_rr_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .req0        (p0.tvalid),
    .req1        (p1.tvalid),
    .last_winner (last_winner_q),
    .gnt         (pick_gnt)
  );

  // Reset gates the datapath so an interrupted TLP cannot leak a beat in the reset cycle.
  assign busy0 = (state_q == ST_BUSY0) && !user_reset;
  assign busy1 = (state_q == ST_BUSY1) && !user_reset;

  always_comb begin
    s_axis_tx.tdata  = p0.tdata;
    s_axis_tx.tkeep  = p0.tkeep;
    s_axis_tx.tlast  = p0.tlast;
    s_axis_tx.tuser  = p0.tuser;
    if (busy1) begin
      s_axis_tx.tdata = p1.tdata;
      s_axis_tx.tkeep = p1.tkeep;
      s_axis_tx.tlast = p1.tlast;
      s_axis_tx.tuser = p1.tuser;
    end
    s_axis_tx.tvalid = (busy0 && p0.tvalid) || (busy1 && p1.tvalid);
    p0.tready        = busy0 && s_axis_tx.tready;
    p1.tready        = busy1 && s_axis_tx.tready;
  end

  assign beat_acc = s_axis_tx.tvalid && s_axis_tx.tready;
  assign tlp_done = beat_acc && s_axis_tx.tlast;

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    p0_pkt_cnt_d  = p0_pkt_cnt_q;
    p1_pkt_cnt_d  = p1_pkt_cnt_q;
    overlong_d    = overlong_q;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        if (tx_cfg_req) begin
          state_d = ST_CFG;
        end else if (pick_gnt[0]) begin
          state_d = ST_BUSY0;
        end else if (pick_gnt[1]) begin
          state_d = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (beat_acc) begin
          beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;
          // beat_cnt_q counts earlier beats, so this is beat MAX_BEATS+1 or later.
          if (!s_axis_tx.tlast && (beat_cnt_q >= OVL_AT)) begin
            overlong_d = 1'b1;
          end
        end
        if (tlp_done) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
          if (state_q == ST_BUSY1) begin
            last_winner_d = 1'b1;
            p1_pkt_cnt_d  = p1_pkt_cnt_q + 1'b1;
          end else begin
            last_winner_d = 1'b0;
            p0_pkt_cnt_d  = p0_pkt_cnt_q + 1'b1;
          end
        end
      end
      ST_CFG: begin
        beat_cnt_d = '0;
        if (!tx_cfg_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_gnt_d = (state_d == ST_CFG);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q       <= ST_IDLE;
      last_winner_q <= 1'b1;
      beat_cnt_q    <= '0;
      p0_pkt_cnt_q  <= '0;
      p1_pkt_cnt_q  <= '0;
      overlong_q    <= 1'b0;
      cfg_gnt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
      p0_pkt_cnt_q  <= p0_pkt_cnt_d;
      p1_pkt_cnt_q  <= p1_pkt_cnt_d;
      overlong_q    <= overlong_d;
      cfg_gnt_q     <= cfg_gnt_d;
    end
  end

  assign tx_cfg_gnt = cfg_gnt_q;
  assign p0_pkt_cnt = p0_pkt_cnt_q;
  assign p1_pkt_cnt = p1_pkt_cnt_q;
  assign overlong   = overlong_q;

endmodule
